// File: rtl/ysyx_25050148_lsu.sv
// NPC load/store unit: one operation in flight, emulated access latency,
// misalignment/illegal-op screening and a held response for write-back.
module ysyx_25050148_lsu #(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_load,
  input  logic        in_store,
  input  logic [2:0]  in_func3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_err,
  output logic        read_valid,
  output logic [31:0] raddr,
  output logic [2:0]  func3,
  output logic        write_valid,
  output logic        wen,
  output logic [31:0] waddr,
  output logic [3:0]  wmask,
  output logic [31:0] wdata,
  input  logic [31:0] read_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t      r_state;
  state_t      w_nxt;
  logic        r_load;
  logic        r_store;
  logic [2:0]  r_func3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_cnt;
  logic [31:0] r_data;
  logic        r_err;

  logic w_ld_ok;
  logic w_st_ok;
  logic w_illegal;
  logic w_misal;
  logic w_err;
  logic w_mem;
  logic w_acc;
  logic w_last;

  always_comb begin
    w_ld_ok = 1'b0;
    w_st_ok = 1'b0;
    unique case (in_func3)
      3'b000, 3'b001, 3'b010: begin
        w_ld_ok = 1'b1;
        w_st_ok = 1'b1;
      end
      3'b100, 3'b101: w_ld_ok = 1'b1;
      default: ;
    endcase
    w_illegal = (in_load & in_store)
              | (in_load & ~w_ld_ok)
              | (in_store & ~w_st_ok);
    // size comes from func3[1:0]: 01 half, 10 word
    w_misal = (in_load | in_store)
            & (((in_func3[1:0] == 2'b01) & in_addr[0])
            | ((in_func3[1:0] == 2'b10) & (|in_addr[1:0])));
    w_err = w_illegal | w_misal;
    w_mem = (in_load | in_store) & ~w_err;
  end

  assign w_acc  = (r_state == S_IDLE) & in_valid;
  assign w_last = (r_state == S_ACCESS) & (r_cnt == 4'd0);

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (in_valid) w_nxt = w_mem ? S_ACCESS : S_RESP;
      S_ACCESS: if (r_cnt == 4'd0) w_nxt = S_RESP;
      S_RESP:   if (out_ready) w_nxt = S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_load  <= 1'b0;
      r_store <= 1'b0;
      r_func3 <= 3'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_cnt   <= 4'd0;
      r_data  <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_acc) begin
        r_load  <= in_load;
        r_store <= in_store;
        r_func3 <= in_func3;
        r_addr  <= in_addr;
        r_wdata <= in_wdata;
        r_cnt   <= LAT_M1;
        r_data  <= 32'd0;
        r_err   <= w_err;
      end else if (r_state == S_ACCESS) begin
        if (r_cnt == 4'd0) begin
          r_data <= r_load ? read_data : 32'd0;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
      end
    end
  end

  always_comb begin
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_data    = 32'd0;
    out_err     = 1'b0;
    read_valid  = 1'b0;
    raddr       = 32'd0;
    func3       = 3'd0;
    write_valid = 1'b0;
    wen         = 1'b0;
    waddr       = 32'd0;
    wmask       = 4'd0;
    wdata       = 32'd0;
    unique case (r_state)
      S_IDLE: in_ready = 1'b1;
      S_ACCESS: begin
        read_valid = r_load;
        raddr      = r_addr;
        waddr      = r_addr;
        wdata      = r_wdata;
        func3      = r_func3;
        // single write on the final access cycle
        if (r_store & w_last) begin
          write_valid = 1'b1;
          wen         = 1'b1;
          unique case (r_func3[1:0])
            2'b00:   wmask = 4'b0001;
            2'b01:   wmask = 4'b0011;
            default: wmask = 4'b1111;
          endcase
        end
      end
      S_RESP: begin
        out_valid = 1'b1;
        out_data  = r_data;
        out_err   = r_err;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_25050148_lsu.sv
// Directed bench for ysyx_25050148_lsu: four instances with LATENCY 1..4
// share clock and reset; each scenario drives one of them.
module tb_ysyx_25050148_lsu;

  logic clk;
  logic rst_n;

  logic        iv   [4];
  logic        ir   [4];
  logic        ild  [4];
  logic        ist  [4];
  logic [2:0]  if3  [4];
  logic [31:0] ia   [4];
  logic [31:0] iw   [4];
  logic        ov   [4];
  logic        ordy [4];
  logic [31:0] od   [4];
  logic        oe   [4];
  logic        rv   [4];
  logic [31:0] ra   [4];
  logic [2:0]  f3   [4];
  logic        wv   [4];
  logic        we   [4];
  logic [31:0] wa   [4];
  logic [3:0]  wm   [4];
  logic [31:0] wd   [4];
  logic [31:0] rdat [4];
  logic [31:0] rdv  [4];

  int wcnt [4];
  int rcnt [4];
  int checks;
  int failures;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    ysyx_25050148_lsu #(.LATENCY(g + 1)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (iv[g]),
      .in_ready   (ir[g]),
      .in_load    (ild[g]),
      .in_store   (ist[g]),
      .in_func3   (if3[g]),
      .in_addr    (ia[g]),
      .in_wdata   (iw[g]),
      .out_valid  (ov[g]),
      .out_ready  (ordy[g]),
      .out_data   (od[g]),
      .out_err    (oe[g]),
      .read_valid (rv[g]),
      .raddr      (ra[g]),
      .func3      (f3[g]),
      .write_valid(wv[g]),
      .wen        (we[g]),
      .waddr      (wa[g]),
      .wmask      (wm[g]),
      .wdata      (wd[g]),
      .read_data  (rdat[g])
    );
    assign rdat[g] = rv[g] ? rdv[g] : 32'h0BAD0BAD;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (wv[k] && we[k]) wcnt[k] = wcnt[k] + 1;
      if (rv[k]) rcnt[k] = rcnt[k] + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_rst(input int k);
    chk("rst_in_ready", 32'(ir[k]), 32'd1);
    chk("rst_out_valid", 32'(ov[k]), 32'd0);
    chk("rst_out_data", od[k], 32'd0);
    chk("rst_out_err", 32'(oe[k]), 32'd0);
    chk("rst_read_valid", 32'(rv[k]), 32'd0);
    chk("rst_write_valid", 32'(wv[k]), 32'd0);
    chk("rst_wen", 32'(we[k]), 32'd0);
    chk("rst_wmask", 32'(wm[k]), 32'd0);
    chk("rst_raddr", ra[k], 32'd0);
    chk("rst_waddr", wa[k], 32'd0);
    chk("rst_wdata", wd[k], 32'd0);
    chk("rst_func3", 32'(f3[k]), 32'd0);
  endtask

  // present one op at a negedge; returns at the negedge of cycle T+1
  task automatic issue(input int k, input logic ld, input logic st,
                       input logic [2:0] fn, input logic [31:0] ad,
                       input logic [31:0] wdt);
    iv[k]  = 1'b1;
    ild[k] = ld;
    ist[k] = st;
    if3[k] = fn;
    ia[k]  = ad;
    iw[k]  = wdt;
    chk("issue_ready", 32'(ir[k]), 32'd1);
    step();
    iv[k] = 1'b0;
  endtask

  logic        s_ld [3];
  logic        s_st [3];
  logic [2:0]  s_fn [3];
  logic [31:0] s_ad [3];
  logic [31:0] s_rd [3];
  logic [31:0] s_ex [3];
  int acc [3];
  int idx;
  int nres;
  int w0;
  int r0;

  initial begin
    checks = 0;
    failures = 0;
    for (int k = 0; k < 4; k++) begin
      iv[k] = 0; ild[k] = 0; ist[k] = 0; if3[k] = 0;
      ia[k] = 0; iw[k] = 0; ordy[k] = 1; rdv[k] = 0;
      wcnt[k] = 0; rcnt[k] = 0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk_rst(0);
    chk_rst(3);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // lw, LATENCY=1
    rdv[0] = 32'hDEADBEEF;
    issue(0, 1, 0, 3'b010, 32'h80000010, 32'h0);
    chk("lw_rv_t1", 32'(rv[0]), 32'd1);
    chk("lw_raddr", ra[0], 32'h80000010);
    chk("lw_func3", 32'(f3[0]), 32'd2);
    chk("lw_ov_t1", 32'(ov[0]), 32'd0);
    chk("lw_ir_t1", 32'(ir[0]), 32'd0);
    step();
    chk("lw_ov_t2", 32'(ov[0]), 32'd1);
    chk("lw_data", od[0], 32'hDEADBEEF);
    chk("lw_err", 32'(oe[0]), 32'd0);
    chk("lw_rv_t2", 32'(rv[0]), 32'd0);
    step();
    chk("lw_idle", 32'(ir[0]), 32'd1);

    // sh, LATENCY=3
    w0 = wcnt[2];
    issue(2, 0, 1, 3'b001, 32'h80000022, 32'h12345678);
    chk("sh_wv_t1", 32'(wv[2]), 32'd0);
    step();
    chk("sh_wv_t2", 32'(wv[2]), 32'd0);
    step();
    chk("sh_wv_t3", 32'(wv[2]), 32'd1);
    chk("sh_wen_t3", 32'(we[2]), 32'd1);
    chk("sh_wmask", 32'(wm[2]), 32'h3);
    chk("sh_wdata", wd[2], 32'h12345678);
    chk("sh_waddr", wa[2], 32'h80000022);
    step();
    chk("sh_ov_t4", 32'(ov[2]), 32'd1);
    chk("sh_data", od[2], 32'd0);
    chk("sh_wv_t4", 32'(wv[2]), 32'd0);
    chk("sh_wcount", 32'(wcnt[2] - w0), 32'd1);
    step();

    // misaligned lw, then sb at odd address
    w0 = wcnt[0];
    r0 = rcnt[0];
    issue(0, 1, 0, 3'b010, 32'h80000002, 32'h0);
    chk("mis_ov_t1", 32'(ov[0]), 32'd1);
    chk("mis_err", 32'(oe[0]), 32'd1);
    step();
    chk("mis_idle", 32'(ir[0]), 32'd1);
    chk("mis_no_read", 32'(rcnt[0] - r0), 32'd0);
    chk("mis_no_write", 32'(wcnt[0] - w0), 32'd0);
    issue(0, 0, 1, 3'b000, 32'h80000003, 32'hA5A5A5A5);
    chk("sb_wv", 32'(wv[0]), 32'd1);
    chk("sb_wmask", 32'(wm[0]), 32'h1);
    chk("sb_waddr", wa[0], 32'h80000003);
    step();
    chk("sb_ov", 32'(ov[0]), 32'd1);
    chk("sb_err", 32'(oe[0]), 32'd0);
    step();

    // illegal: load and store together
    issue(0, 1, 1, 3'b010, 32'h80000000, 32'h0);
    chk("ill_ov", 32'(ov[0]), 32'd1);
    chk("ill_err", 32'(oe[0]), 32'd1);
    step();

    // lb with backpressure
    ordy[0] = 1'b0;
    rdv[0] = 32'hFFFFFF80;
    issue(0, 1, 0, 3'b000, 32'h80000003, 32'h0);
    chk("lb_rv", 32'(rv[0]), 32'd1);
    chk("lb_func3", 32'(f3[0]), 32'd0);
    step();
    rdv[0] = 32'h0;
    for (int c = 0; c < 5; c++) begin
      chk("bp_ov", 32'(ov[0]), 32'd1);
      chk("bp_data", od[0], 32'hFFFFFF80);
      chk("bp_ir", 32'(ir[0]), 32'd0);
      chk("bp_rv", 32'(rv[0]), 32'd0);
      if (c < 4) step();
    end
    ordy[0] = 1'b1;
    step();
    chk("bp_idle", 32'(ir[0]), 32'd1);
    chk("bp_ov_low", 32'(ov[0]), 32'd0);

    // sw, LATENCY=4, reset in the 2nd access cycle
    w0 = wcnt[3];
    issue(3, 0, 1, 3'b010, 32'h80000040, 32'h55667788);
    chk("rsw_busy", 32'(ir[3]), 32'd0);
    step();
    rst_n = 1'b0;
    #1;
    chk_rst(3);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) step();
    chk("rsw_no_write", 32'(wcnt[3] - w0), 32'd0);
    chk("rsw_no_resp", 32'(ov[3]), 32'd0);
    rdv[3] = 32'hCAFEF00D;
    issue(3, 1, 0, 3'b010, 32'h80000044, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      chk("rlw_rv", 32'(rv[3]), 32'd1);
      chk("rlw_ov_low", 32'(ov[3]), 32'd0);
      step();
    end
    chk("rlw_ov", 32'(ov[3]), 32'd1);
    chk("rlw_data", od[3], 32'hCAFEF00D);
    chk("rlw_err", 32'(oe[3]), 32'd0);
    step();

    // lbu / sw / lhu stream, LATENCY=2
    s_ld[0] = 1; s_st[0] = 0; s_fn[0] = 3'b100;
    s_ad[0] = 32'h80000001; s_rd[0] = 32'h000000AB; s_ex[0] = 32'h000000AB;
    s_ld[1] = 0; s_st[1] = 1; s_fn[1] = 3'b010;
    s_ad[1] = 32'h80000004; s_rd[1] = 32'h0; s_ex[1] = 32'h0;
    s_ld[2] = 1; s_st[2] = 0; s_fn[2] = 3'b101;
    s_ad[2] = 32'h80000006; s_rd[2] = 32'h0000BEEF; s_ex[2] = 32'h0000BEEF;
    iw[1] = 32'h11223344;
    idx = 0;
    nres = 0;
    w0 = wcnt[1];
    for (int c = 0; c < 16; c++) begin
      if (ov[1]) begin
        if (nres < 3) chk("str_data", od[1], s_ex[nres]);
        chk("str_err", 32'(oe[1]), 32'd0);
        nres++;
      end
      if (wv[1]) begin
        chk("str_wmask", 32'(wm[1]), 32'hF);
        chk("str_wdata", wd[1], 32'h11223344);
      end
      if (idx < 3) begin
        iv[1] = 1'b1;
        ild[1] = s_ld[idx];
        ist[1] = s_st[idx];
        if3[1] = s_fn[idx];
        ia[1] = s_ad[idx];
        if (ir[1]) begin
          acc[idx] = c;
          rdv[1] = s_rd[idx];
          idx++;
        end
      end else begin
        iv[1] = 1'b0;
      end
      step();
    end
    chk("str_accepts", 32'(idx), 32'd3);
    chk("str_gap01", 32'(acc[1] - acc[0]), 32'd4);
    chk("str_gap12", 32'(acc[2] - acc[1]), 32'd4);
    chk("str_results", 32'(nres), 32'd3);
    chk("str_writes", 32'(wcnt[1] - w0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
